// File: rtl/multibyte_add_sequencer.sv
// Byte-serial add/subtract sequencer around an external 8-bit adder.
// Optional signed-overflow output enabled by ADD_SEQ_OVERFLOW_EN.
module multibyte_add_sequencer #(
    parameter int NUM_BYTES = 4,
    localparam int W = 8 * NUM_BYTES,
    localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         op_cin,
    input  logic         op_sub,
    output logic [7:0]   adder_a,
    output logic [7:0]   adder_b,
    output logic         adder_cin,
    input  logic [7:0]   adder_sum,
    input  logic         adder_cout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         result_cout,
`ifdef ADD_SEQ_OVERFLOW_EN
    output logic         result_ovf,
`endif
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [NUM_BYTES-1:0][7:0] a_q;
    logic [NUM_BYTES-1:0][7:0] b_q;
    logic [NUM_BYTES-1:0][7:0] res_q;
    logic                      sub_q;
    logic                      carry_q;
    logic                      cout_q;
    logic [IW-1:0]             idx_q;
    logic                      last;
    logic                      accept;

    assign accept = (state_q == IDLE) && in_valid;
    assign last = (idx_q == IW'(NUM_BYTES - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: accept in IDLE, run one byte per cycle, hold until taken
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Adder drive: only the active byte during RUN, zero otherwise
    always_comb begin
        adder_a   = 8'd0;
        adder_b   = 8'd0;
        adder_cin = 1'b0;
        if (state_q == RUN) begin
            adder_a   = a_q[idx_q];
            adder_b   = sub_q ? ~b_q[idx_q] : b_q[idx_q];
            adder_cin = carry_q;
        end
    end

    // Operand capture, carry chaining and result byte collection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else if (accept) begin
            a_q     <= op_a;
            b_q     <= op_b;
            sub_q   <= op_sub;
            carry_q <= op_sub ? 1'b1 : op_cin;
            res_q   <= '0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else if (state_q == RUN) begin
            res_q[idx_q] <= adder_sum;
            carry_q      <= adder_cout;
            if (last) begin
                cout_q <= adder_cout;
                idx_q  <= '0;
            end else begin
                idx_q <= idx_q + IW'(1);
            end
        end
    end

`ifdef ADD_SEQ_OVERFLOW_EN
    logic ovf_q;

    // Signed overflow from the top byte's sign bits on the final RUN edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (accept) begin
            ovf_q <= 1'b0;
        end else if (state_q == RUN && last) begin
            ovf_q <= (adder_a[7] == adder_b[7]) &&
                     (adder_sum[7] != adder_a[7]);
        end
    end

    assign result_ovf = ovf_q;
`endif

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign result      = res_q;
    assign result_cout = cout_q;

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// Self-checking bench for multibyte_add_sequencer (NUM_BYTES=4).
// Directed cases plus random operations against an arithmetic model.
module tb_multibyte_add_sequencer;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_cin;
    logic         op_sub;
    logic [7:0]   adder_a;
    logic [7:0]   adder_b;
    logic         adder_cin;
    logic [7:0]   adder_sum;
    logic         adder_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         result_cout;
    logic         busy;
`ifdef ADD_SEQ_OVERFLOW_EN
    logic         result_ovf;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // The 8-bit ripple adder the sequencer wraps
    assign {adder_cout, adder_sum} =
        {1'b0, adder_a} + {1'b0, adder_b} + {8'd0, adder_cin};

    multibyte_add_sequencer #(.NUM_BYTES(NB)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .op_a(op_a),
        .op_b(op_b),
        .op_cin(op_cin),
        .op_sub(op_sub),
        .adder_a(adder_a),
        .adder_b(adder_b),
        .adder_cin(adder_cin),
        .adder_sum(adder_sum),
        .adder_cout(adder_cout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .result_cout(result_cout),
`ifdef ADD_SEQ_OVERFLOW_EN
        .result_ovf(result_ovf),
`endif
        .busy(busy)
    );

    task automatic chk(input logic [63:0] obs, input logic [63:0] exp,
                       input string tag);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({63'd0, in_ready}, 64'd1, {tag, " in_ready"});
        chk({63'd0, out_valid}, 64'd0, {tag, " out_valid"});
        chk({63'd0, busy}, 64'd0, {tag, " busy"});
        chk({55'd0, adder_a, adder_b[0]}, 64'd0, {tag, " adder_a"});
        chk({56'd0, adder_b}, 64'd0, {tag, " adder_b"});
        chk({63'd0, adder_cin}, 64'd0, {tag, " adder_cin"});
    endtask

    // Full operation: accept, check every RUN byte, latency, result, handshake
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub,
                          input int hold, input string tag);
        logic [W-1:0] exp_res;
        logic         exp_cout;
        logic [W-1:0] beff;
        logic         cin0;
        logic [63:0]  lower;
        logic [63:0]  mask;
        logic [63:0]  bb;
        int           edges;
        if (sub) begin
            exp_res  = a - b;
            exp_cout = (a >= b);
        end else begin
            {exp_cout, exp_res} = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        end
        beff = sub ? ~b : b;
        cin0 = sub ? 1'b1 : cin;
        chk({63'd0, in_ready}, 64'd1, {tag, " in_ready pre"});
        op_a = a;
        op_b = b;
        op_cin = cin;
        op_sub = sub;
        in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
        edges = 1;
        for (int k = 0; k < NB; k++) begin
            mask = (64'd1 << (8 * k)) - 64'd1;
            lower = ({32'd0, a} & mask) + ({32'd0, beff} & mask) +
                    {63'd0, cin0};
            bb = {32'd0, beff} >> (8 * k);
            chk({63'd0, busy}, 64'd1, {tag, " busy run"});
            chk({63'd0, in_ready}, 64'd0, {tag, " in_ready run"});
            chk({63'd0, out_valid}, 64'd0, {tag, " out_valid run"});
            chk({56'd0, adder_a}, ({32'd0, a} >> (8 * k)) & 64'hFF,
                {tag, " adder_a"});
            chk({56'd0, adder_b}, bb & 64'hFF, {tag, " adder_b"});
            chk({63'd0, adder_cin}, (lower >> (8 * k)) & 64'd1,
                {tag, " adder_cin"});
            tick();
            edges++;
        end
        chk({63'd0, out_valid}, 64'd1, {tag, " out_valid"});
        chk(64'(edges), 64'(NB + 1), {tag, " latency"});
        chk({63'd0, busy}, 64'd1, {tag, " busy done"});
        chk({32'd0, result}, {32'd0, exp_res}, {tag, " result"});
        chk({63'd0, result_cout}, {63'd0, exp_cout}, {tag, " cout"});
`ifdef ADD_SEQ_OVERFLOW_EN
        chk({63'd0, result_ovf},
            {63'd0, (a[W-1] == beff[W-1]) && (exp_res[W-1] != a[W-1])},
            {tag, " ovf"});
`endif
        chk({55'd0, adder_a, adder_cin}, 64'd0, {tag, " adder done"});
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            op_a = $urandom;
            op_b = $urandom;
            tick();
            chk({63'd0, out_valid}, 64'd1, {tag, " hold valid"});
            chk({63'd0, in_ready}, 64'd0, {tag, " hold in_ready"});
            chk({32'd0, result}, {32'd0, exp_res}, {tag, " hold result"});
            chk({63'd0, result_cout}, {63'd0, exp_cout},
                {tag, " hold cout"});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk_idle({tag, " after"});
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op_a = '0;
        op_b = '0;
        op_cin = 1'b0;
        op_sub = 1'b0;
        #12;
        chk_idle("reset");
        chk({32'd0, result}, 64'd0, "reset result");
        chk({63'd0, result_cout}, 64'd0, "reset cout");
        @(negedge clk);
        rst = 1'b0;
        tick();

        run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 0, "t1");
        run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 0, "t2");
        run_op(32'h00000005, 32'h00000007, 1'b1, 1'b1, 0, "t3a");
        run_op(32'h00000007, 32'h00000005, 1'b1, 1'b1, 0, "t3b");
        run_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, 3, "t4");
        run_op(32'hCAFEF00D, 32'h0BADBEEF, 1'b1, 1'b0, 0, "t4next");

        // Asynchronous reset two RUN cycles into an operation
        op_a = 32'hDEADBEEF;
        op_b = 32'h01020304;
        op_cin = 1'b1;
        op_sub = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk_idle("midrst");
        chk({32'd0, result}, 64'd0, "midrst result");
        @(negedge clk);
        rst = 1'b0;
        tick();
        run_op(32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1, 1'b0, 0, "t5next");

        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 0, "t6a");
        run_op(32'h80000000, 32'h00000001, 1'b0, 1'b1, 0, "t6b");

        for (int r = 0; r < 20; r++) begin
            run_op($urandom, $urandom, 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 2)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
